// File: rtl/adia_pkg.sv
// Shared types and helpers for the adiabatic power-clock sequencer.
package adia_pkg;

    localparam int unsigned RAMP_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        HOLD    = 2'd2,
        RECOVER = 2'd3
    } seq_state_e;

    // Full-rail code for a w-bit ramp.
    function automatic int unsigned cmax(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // LSB position of stage k inside a flattened per-stage code bus.
    function automatic int unsigned stage_slice(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/adia_ramp_step.sv
// Per-stage saturating up/down ramp counter driving one charge-DAC code.
module adia_ramp_step
    import adia_pkg::*;
#(
    parameter int unsigned RAMP_W = RAMP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [RAMP_W-1:0] code,
    output logic              at_max,
    output logic              at_zero
);

    localparam logic [RAMP_W-1:0] CMAX_C = RAMP_W'(cmax(RAMP_W));

    assign at_max  = (code == CMAX_C);
    assign at_zero = (code == '0);

    // Ramp register: steps by one, never wraps past either rail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code <= '0;
        end else if (inc && !at_max) begin
            code <= code + RAMP_W'(1);
        end else if (dec && !at_zero) begin
            code <= code - RAMP_W'(1);
        end
    end

endmodule

// File: rtl/adia_clk_sequencer.sv
// Power-clock sequencer for a retractile cascade of adiabatic logic stages.
// Charges stages 0..NSTAGE-1 in order, holds for the result, recovers in reverse.
// Optional macro ADIA_DWELL_EN inserts DWELL plateau cycles between stage ramps.
module adia_clk_sequencer
    import adia_pkg::*;
#(
    parameter int unsigned NSTAGE = 4,
    parameter int unsigned RAMP_W = RAMP_W_DEF,
    parameter int unsigned DWELL  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    output logic                     in_latch,
    output logic [NSTAGE*RAMP_W-1:0] clkpos_code,
    output logic [NSTAGE*RAMP_W-1:0] clkneg_code,
    output logic                     result_valid,
    input  logic                     result_ack,
    output logic                     busy
);

    localparam int unsigned       SIDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [RAMP_W-1:0] CMAX_C = RAMP_W'(cmax(RAMP_W));
    localparam logic [SIDX_W-1:0] LAST   = SIDX_W'(NSTAGE - 1);

    seq_state_e        state, state_nx;
    logic [SIDX_W-1:0] sidx, sidx_nx;
    logic [NSTAGE-1:0] inc_v, dec_v, at_max, at_zero;
    logic              in_latch_nx;
    logic              dwell_ok;
    logic              plateau;

`ifdef ADIA_DWELL_EN
    localparam int unsigned DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    logic [DW_W-1:0] dwell_cnt, dwell_nx;

    assign dwell_ok = (dwell_cnt == DW_W'(DWELL));

    // Plateau counter runs only while a finished stage waits for its neighbour.
    always_comb begin
        dwell_nx = plateau ? dwell_cnt + DW_W'(1) : '0;
    end

    // Plateau counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_nx;
        end
    end
`else
    logic unused_dwell;

    assign dwell_ok     = 1'b1;
    assign unused_dwell = ^{DWELL, plateau};
`endif

    // Next-state logic and per-stage inc/dec steering from the stage index.
    always_comb begin
        state_nx = state;
        sidx_nx  = sidx;
        inc_v    = '0;
        dec_v    = '0;
        plateau  = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && op_ready) begin
                    state_nx = CHARGE;
                    sidx_nx  = '0;
                    inc_v[0] = 1'b1;
                end
            end
            CHARGE: begin
                if (!at_max[sidx]) begin
                    inc_v[sidx] = 1'b1;
                end else if (sidx == LAST) begin
                    state_nx = HOLD;
                end else if (dwell_ok) begin
                    sidx_nx        = sidx + SIDX_W'(1);
                    inc_v[sidx_nx] = 1'b1;
                end else begin
                    plateau = 1'b1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_nx    = RECOVER;
                    sidx_nx     = LAST;
                    dec_v[LAST] = 1'b1;
                end
            end
            RECOVER: begin
                if (!at_zero[sidx]) begin
                    dec_v[sidx] = 1'b1;
                end else if (sidx == '0) begin
                    state_nx = IDLE;
                end else if (dwell_ok) begin
                    sidx_nx        = sidx - SIDX_W'(1);
                    dec_v[sidx_nx] = 1'b1;
                end else begin
                    plateau = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        in_latch_nx = (state == IDLE) && (state_nx == CHARGE);
    end

    // State, stage index and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sidx         <= '0;
            op_ready     <= 1'b1;
            in_latch     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            sidx         <= sidx_nx;
            op_ready     <= (state_nx == IDLE);
            in_latch     <= in_latch_nx;
            result_valid <= (state_nx == HOLD);
            busy         <= (state_nx != IDLE);
        end
    end

    // One ramp counter per stage; the negative rail mirrors the positive one.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [RAMP_W-1:0] code;

        adia_ramp_step #(
            .RAMP_W (RAMP_W)
        ) u_step (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_v[k]),
            .dec     (dec_v[k]),
            .code    (code),
            .at_max  (at_max[k]),
            .at_zero (at_zero[k])
        );

        assign clkpos_code[stage_slice(k, RAMP_W) +: RAMP_W] = code;
        assign clkneg_code[stage_slice(k, RAMP_W) +: RAMP_W] = CMAX_C - code;
    end

endmodule

// File: tb/tb_adia_clk_sequencer.sv
// Bench for adia_clk_sequencer with NSTAGE=3, RAMP_W=2 (CMAX=3), DWELL=2.
module tb_adia_clk_sequencer;

    localparam int unsigned NS = 3;
    localparam int unsigned RW = 2;
    localparam int unsigned DW = 2;
    localparam int unsigned PW = NS * RW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          result_ack = 1'b0;
    logic          op_ready, in_latch, result_valid, busy;
    logic [PW-1:0] clkpos_code, clkneg_code;

    always #5 clk = ~clk;

    adia_clk_sequencer #(
        .NSTAGE (NS),
        .RAMP_W (RW),
        .DWELL  (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .in_latch     (in_latch),
        .clkpos_code  (clkpos_code),
        .clkneg_code  (clkneg_code),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .busy         (busy)
    );

    // Inputs for one cycle and the outputs expected in the following cycle.
    typedef struct {
        logic          ov;
        logic          ack;
        logic [PW-1:0] pos;
        logic          il;
        logic          rv;
        logic          rdy;
        logic          bsy;
    } vec_t;

    vec_t   vecs [0:31];
    int     nvec = 0;
    vec_t   sb [$];
    int     nerr = 0;
    int     nchk = 0;
    bit     mon_en = 1'b0;
    bit     prev_ok = 1'b0;
    int     latch_cnt = 0;
    logic [PW-1:0] prev_pos;
    logic [PW-1:0] mp;
    bit     bad;

    task automatic sv(input logic ov, input logic ack, input logic [1:0] s0,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic il, input logic rv, input logic rdy);
        vecs[nvec].ov  = ov;
        vecs[nvec].ack = ack;
        vecs[nvec].pos = {s2, s1, s0};
        vecs[nvec].il  = il;
        vecs[nvec].rv  = rv;
        vecs[nvec].rdy = rdy;
        vecs[nvec].bsy = ~rdy;
        nvec++;
    endtask

    task automatic check_out(input string nm, input int idx, input vec_t e);
        logic [PW-1:0] eneg;
        for (int k = 0; k < NS; k++) eneg[k*RW +: RW] = 2'd3 - e.pos[k*RW +: RW];
        nchk++;
        if (clkpos_code !== e.pos || clkneg_code !== eneg || in_latch !== e.il ||
            result_valid !== e.rv || op_ready !== e.rdy || busy !== e.bsy) begin
            nerr++;
            $display("FAIL %s[%0d]: got pos=%h neg=%h il=%b rv=%b rdy=%b busy=%b, want pos=%h neg=%h il=%b rv=%b rdy=%b busy=%b",
                     nm, idx, clkpos_code, clkneg_code, in_latch, result_valid, op_ready, busy,
                     e.pos, eneg, e.il, e.rv, e.rdy, e.bsy);
        end
    endtask

    task automatic wait_rv(input int budget);
        int n = 0;
        while (result_valid !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        nchk++;
        if (result_valid !== 1'b1) begin
            nerr++;
            $display("FAIL wait_rv: result_valid=%b after %0d cycles, want 1", result_valid, n);
        end
    endtask

    task automatic wait_rdy(input int budget);
        int n = 0;
        while (op_ready !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        nchk++;
        if (op_ready !== 1'b1) begin
            nerr++;
            $display("FAIL wait_rdy: op_ready=%b after %0d cycles, want 1", op_ready, n);
        end
    endtask

    // Cascade-order invariant, rail complement and no-wrap monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_ok = 1'b0;
        end else if (mon_en) begin
            mp  = clkpos_code;
            bad = 1'b0;
            // With a 2-bit ramp, 3 - x per stage is the bitwise complement.
            if (clkneg_code !== ~mp) bad = 1'b1;
            for (int k = 1; k < NS; k++)
                if (mp[k*RW +: RW] != 2'd0)
                    for (int j = 0; j < k; j++)
                        if (mp[j*RW +: RW] != 2'd3) bad = 1'b1;
            if (prev_ok)
                for (int k = 0; k < NS; k++)
                    if (int'(mp[k*RW +: RW]) > int'(prev_pos[k*RW +: RW]) + 1 ||
                        int'(prev_pos[k*RW +: RW]) > int'(mp[k*RW +: RW]) + 1) bad = 1'b1;
            nchk++;
            if (bad) begin
                nerr++;
                $display("FAIL monitor: pos=%h prev=%h neg=%h violates order/complement/step", mp, prev_pos, clkneg_code);
            end
            if (in_latch) latch_cnt++;
            prev_pos = mp;
            prev_ok  = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   n;

`ifndef ADIA_DWELL_EN
        //  ov ack s0 s1 s2 il rv rdy      (expected values are for the next cycle)
        sv(1, 0, 1, 0, 0, 1, 0, 0);
        sv(0, 0, 2, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 1, 0, 0, 0, 0);
        sv(0, 0, 3, 2, 0, 0, 0, 0);
        sv(1, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 1, 0, 0, 0);
        sv(0, 0, 3, 3, 2, 0, 0, 0);
        sv(0, 0, 3, 3, 3, 0, 0, 0);
        sv(0, 0, 3, 3, 3, 0, 1, 0);
        sv(0, 1, 3, 3, 2, 0, 0, 0);
        sv(0, 0, 3, 3, 1, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 2, 0, 0, 0, 0);
        sv(0, 0, 3, 1, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 2, 0, 0, 0, 0, 0);
        sv(0, 0, 1, 0, 0, 0, 0, 0);
        sv(0, 0, 0, 0, 0, 0, 0, 0);
        sv(0, 0, 0, 0, 0, 0, 0, 1);
`else
        sv(1, 0, 1, 0, 0, 1, 0, 0);
        sv(0, 0, 2, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(1, 0, 3, 1, 0, 0, 0, 0);
        sv(0, 0, 3, 2, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 1, 0, 0, 0);
        sv(0, 0, 3, 3, 2, 0, 0, 0);
        sv(0, 0, 3, 3, 3, 0, 0, 0);
        sv(0, 0, 3, 3, 3, 0, 1, 0);
        sv(0, 1, 3, 3, 2, 0, 0, 0);
        sv(0, 0, 3, 3, 1, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 3, 0, 0, 0, 0);
        sv(0, 0, 3, 2, 0, 0, 0, 0);
        sv(0, 0, 3, 1, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 3, 0, 0, 0, 0, 0);
        sv(0, 0, 2, 0, 0, 0, 0, 0);
        sv(0, 0, 1, 0, 0, 0, 0, 0);
        sv(0, 0, 0, 0, 0, 0, 0, 0);
        sv(0, 0, 0, 0, 0, 0, 0, 1);
`endif

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        e = '{ov: 0, ack: 0, pos: '0, il: 0, rv: 0, rdy: 1, bsy: 0};
        check_out("reset", 0, e);
        @(negedge clk) rst = 1'b0;
        mon_en = 1'b1;

        // Full charge/hold/recover sequence from the vector table.
        for (int c = 0; c < nvec; c++) begin
            @(negedge clk);
            op_valid   = vecs[c].ov;
            result_ack = vecs[c].ack;
            sb.push_back(vecs[c]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out("vec", c + 1, e);
        end
        @(negedge clk);
        op_valid   = 1'b0;
        result_ack = 1'b0;

        // Long hold: result stays valid, codes frozen, op_valid ignored.
        @(negedge clk) op_valid = 1'b1;
        @(negedge clk) op_valid = 1'b0;
        wait_rv(60);
        e = '{ov: 0, ack: 0, pos: '1, il: 0, rv: 1, rdy: 0, bsy: 1};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            op_valid   = 1'($urandom_range(0, 1));
            result_ack = 1'b0;
            @(posedge clk);
            #1;
            check_out("hold", i, e);
        end
        @(negedge clk);
        op_valid   = 1'b0;
        result_ack = 1'b1;
        @(negedge clk) result_ack = 1'b0;
        wait_rdy(60);

        // Asynchronous reset mid-ramp, then a fresh operation.
        @(negedge clk) op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk) op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        e = '{ov: 0, ack: 0, pos: '0, il: 0, rv: 0, rdy: 1, bsy: 0};
        check_out("async_rst", 0, e);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk) op_valid = 1'b1;
        @(posedge clk);
        #1;
        e = '{ov: 0, ack: 0, pos: PW'(1), il: 1, rv: 0, rdy: 0, bsy: 1};
        check_out("restart", 0, e);
        @(negedge clk) op_valid = 1'b0;
        wait_rv(60);
        @(negedge clk) result_ack = 1'b1;
        @(negedge clk) result_ack = 1'b0;
        wait_rdy(60);

        // Randomised traffic; the monitor checks every cycle.
        latch_cnt = 0;
        for (int op = 0; op < 200; op++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk) op_valid = 1'b1;
            n = 0;
            while (n < 80) begin
                @(negedge clk);
                if (result_valid) break;
                op_valid = 1'($urandom_range(0, 1));
                n++;
            end
            op_valid = 1'b0;
            nchk++;
            if (!result_valid) begin
                nerr++;
                $display("FAIL rand_rv[%0d]: result_valid=%b, want 1", op, result_valid);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            result_ack = 1'b1;
            @(negedge clk) result_ack = 1'b0;
            n = 0;
            while (n < 80) begin
                @(negedge clk);
                if (op_ready) break;
                op_valid = 1'($urandom_range(0, 1));
                n++;
            end
            op_valid = 1'b0;
            nchk++;
            if (!op_ready) begin
                nerr++;
                $display("FAIL rand_rdy[%0d]: op_ready=%b, want 1", op, op_ready);
            end
        end
        @(negedge clk);
        nchk++;
        if (latch_cnt != 200) begin
            nerr++;
            $display("FAIL latch_count: got %0d in_latch pulses, want 200", latch_cnt);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
